// File: rtl/decode_ctrl.sv
// Decode-stage controller: 2-entry skid buffer, opcode classification, immediate select.
// Optional DECODE_PERF_EN adds saturating stall_cnt / illegal_cnt outputs.

module imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);
    always_comb begin
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end
endmodule

module decode_ctrl #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [2:0]  imm_sel,
    output logic [31:0] imm,
    output logic        illegal
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] illegal_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;

    localparam logic [2:0] SEL_NONE = 3'd0, SEL_I = 3'd1, SEL_S = 3'd2,
                           SEL_B = 3'd3, SEL_U = 3'd4, SEL_J = 3'd5;

    state_e      state_q, state_d;
    logic        out_valid_q, in_ready_q;
    logic [31:0] main_instr_q, main_instr_d, main_pc_q, main_pc_d;
    logic [2:0]  main_sel_q, main_sel_d;
    logic        main_ill_q, main_ill_d;
    logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
    logic [2:0]  skid_sel_q, skid_sel_d;
    logic        skid_ill_q, skid_ill_d;
    logic [2:0]  in_sel;
    logic        in_ill;
    logic        accept, consume;

    // Classification of the incoming word, stored alongside the entry.
    always_comb begin
        in_sel = SEL_NONE;
        in_ill = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b1110011, 7'b0001111: in_sel = SEL_I;
            7'b0100011:             in_sel = SEL_S;
            7'b1100011:             in_sel = SEL_B;
            7'b0110111, 7'b0010111: in_sel = SEL_U;
            7'b1101111:             in_sel = SEL_J;
            7'b0110011:             in_sel = SEL_NONE;
            default:                in_ill = 1'b1;
        endcase
    end

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        main_sel_d   = main_sel_q;
        main_ill_d   = main_ill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_sel_d   = skid_sel_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d      = BUSY;
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                    main_sel_d   = in_sel;
                    main_ill_d   = in_ill;
                end
                BUSY: begin
                    if (accept && consume) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                        main_sel_d   = in_sel;
                        main_ill_d   = in_ill;
                    end else if (accept) begin
                        state_d      = FULL;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                        skid_sel_d   = in_sel;
                        skid_ill_d   = in_ill;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (consume) begin
                    state_d      = BUSY;
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                    main_sel_d   = skid_sel_q;
                    main_ill_d   = skid_ill_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            main_instr_q <= RESET_INSTR;
            main_pc_q    <= '0;
            main_sel_q   <= SEL_NONE;
            main_ill_q   <= 1'b0;
            skid_instr_q <= RESET_INSTR;
            skid_pc_q    <= '0;
            skid_sel_q   <= SEL_NONE;
            skid_ill_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= (state_d != EMPTY);
            in_ready_q   <= (state_d != FULL);
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            main_sel_q   <= main_sel_d;
            main_ill_q   <= main_ill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_sel_q   <= skid_sel_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    imm_gen u_imm_gen (
        .instr (main_instr_q[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    always_comb begin
        case (main_sel_q)
            SEL_I:   imm = imm_i;
            SEL_S:   imm = imm_s;
            SEL_B:   imm = imm_b;
            SEL_U:   imm = imm_u;
            SEL_J:   imm = imm_j;
            default: imm = '0;
        endcase
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;
    assign imm_sel   = main_sel_q;
    assign illegal   = main_ill_q;

`ifdef DECODE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (out_valid_q && !out_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (consume && main_ill_q && illegal_cnt_q != '1)
            illegal_cnt_d = illegal_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed self-checking bench for decode_ctrl; perf counter checks follow DECODE_PERF_EN.

module tb_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc, imm;
    logic [2:0]  imm_sel;
    logic        illegal;
`ifdef DECODE_PERF_EN
    logic [31:0] stall_cnt, illegal_cnt;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    decode_ctrl #(.RESET_INSTR(32'h0000_0013)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .imm_sel   (imm_sel),
        .imm       (imm),
        .illegal   (illegal)
`ifdef DECODE_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] s_instr [4];
    logic [2:0]  s_sel   [4];
    logic [31:0] s_imm   [4];

    initial begin
        s_instr[0] = 32'hFE11_2E23; s_sel[0] = 3'd2; s_imm[0] = 32'hFFFF_FFFC;
        s_instr[1] = 32'hFE00_0EE3; s_sel[1] = 3'd3; s_imm[1] = 32'hFFFF_FFFC;
        s_instr[2] = 32'h1234_50B7; s_sel[2] = 3'd4; s_imm[2] = 32'h1234_5000;
        s_instr[3] = 32'h0080_00EF; s_sel[3] = 3'd5; s_imm[3] = 32'h0000_0008;

        // reset values
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_illegal",   {31'b0, illegal},   32'd0);
        check("rst_imm_sel",   {29'b0, imm_sel},   32'd0);
        check("rst_out_instr", out_instr,          32'h0000_0013);
        check("rst_out_pc",    out_pc,             32'd0);
        #4 rst = 1'b0;
        step();

        // single addi
        in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h100; out_ready = 1'b1;
        step();
        check("addi_valid",   {31'b0, out_valid}, 32'd1);
        check("addi_sel",     {29'b0, imm_sel},   32'd1);
        check("addi_imm",     imm,                32'd0);
        check("addi_illegal", {31'b0, illegal},   32'd0);
        check("addi_pc",      out_pc,             32'h100);
        in_valid = 1'b0;
        step();
        check("addi_drained", {31'b0, out_valid}, 32'd0);

        // back-to-back stream
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_instr = s_instr[k]; in_pc = 32'h200 + 32'(4 * k);
            step();
            check("strm_valid", {31'b0, out_valid}, 32'd1);
            check("strm_ready", {31'b0, in_ready},  32'd1);
            check("strm_instr", out_instr,          s_instr[k]);
            check("strm_pc",    out_pc,             32'h200 + 32'(4 * k));
            check("strm_sel",   {29'b0, imm_sel},   {29'b0, s_sel[k]});
            check("strm_imm",   imm,                s_imm[k]);
        end
        in_valid = 1'b0;
        step();
        check("strm_drained", {31'b0, out_valid}, 32'd0);

        // backpressure: three offered, two accepted
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0093;
        step();
        check("bp_a_valid", {31'b0, out_valid}, 32'd1);
        check("bp_a_ready", {31'b0, in_ready},  32'd1);
        in_instr = 32'h0020_0113;
        step();
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_a",     out_instr,         32'h0010_0093);
        check("bp_imm_a",      imm,               32'd1);
        in_instr = 32'h0030_0193;
        step();
        check("bp_still_full", {31'b0, in_ready}, 32'd0);
        check("bp_stable_a",   out_instr,         32'h0010_0093);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_b_instr", out_instr,          32'h0020_0113);
        check("bp_b_imm",   imm,                32'd2);
        check("bp_b_ready", {31'b0, in_ready},  32'd1);
        check("bp_b_valid", {31'b0, out_valid}, 32'd1);
        step();
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // illegal opcode
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000_007F;
        step();
        check("ill_flag", {31'b0, illegal}, 32'd1);
        check("ill_sel",  {29'b0, imm_sel}, 32'd0);
        check("ill_imm",  imm,              32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("ill_drained", {31'b0, out_valid}, 32'd0);
`ifdef DECODE_PERF_EN
        check("ill_cnt", illegal_cnt, 32'd1);
        check("stall_cnt_a", stall_cnt, 32'd2);
`endif

        // flush while FULL with a beat offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0040_0213;
        step();
        in_instr = 32'h0050_0293;
        step();
        check("fl_full", {31'b0, in_ready}, 32'd0);
        flush = 1'b1; in_instr = 32'h0060_0313;
        step();
        check("fl_valid", {31'b0, out_valid}, 32'd0);
        check("fl_ready", {31'b0, in_ready},  32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("fl_dropped", {31'b0, out_valid}, 32'd0);
`ifdef DECODE_PERF_EN
        check("stall_cnt_b", stall_cnt, 32'd4);
`endif

        // async reset while BUSY
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0070_0393;
        step();
        check("ar_busy",  {31'b0, out_valid}, 32'd1);
        check("ar_instr", out_instr,          32'h0070_0393);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_valid",     {31'b0, out_valid}, 32'd0);
        check("ar_out_instr", out_instr,          32'h0000_0013);
        check("ar_in_ready",  {31'b0, in_ready},  32'd1);
`ifdef DECODE_PERF_EN
        check("ar_stall_cnt", stall_cnt, 32'd0);
`endif
        #1 rst = 1'b0;
        step();
        check("ar_after", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Decode-stage controller for the rv32im core. Sits between fetch and execute.
- Accepts instructions over a valid/ready handshake and holds them in a 2-entry skid buffer.
- Classifies each opcode into an immediate format and flags illegal encodings.
- Drives the immediate select and the selected 32-bit immediate from the instance of imm_gen that it wraps.

Parameters:
- RESET_INSTR, 32'h0000_0013, value loaded into the held-instruction registers on reset (NOP).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all buffered instructions; sampled on the clock edge.
- in_valid  input  1  fetch presents an instruction.
- in_instr  input  32  fetched instruction word.
- in_pc  input  32  PC of in_instr.
- in_ready  output  1  decode can accept a beat (registered).
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  execute accepts the decoded instruction.
- out_instr  output  32  held instruction (main entry).
- out_pc  output  32  PC of out_instr.
- imm_sel  output  3  immediate format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- imm  output  32  immediate chosen by imm_sel from imm_gen outputs; 0 when imm_sel is NONE.
- illegal  output  1  out_instr has an unsupported opcode.

Behaviour:
- Reset values:
  - out_valid=0, in_ready=1, illegal=0, imm_sel=0.
  - out_instr and skid instr = RESET_INSTR; out_pc = 0.
  - state = EMPTY.
- Handshakes:
  - An input beat is accepted when in_valid & in_ready.
  - An output beat is consumed when out_valid & out_ready.
  - out_* stay stable while out_valid & !out_ready.
- Classification happens at capture; imm_sel and illegal are registered with the entry.
- Opcode to format (instr[6:0]):
  - 0000011, 0010011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011 -> NONE, legal.
  - Anything else -> NONE with illegal=1. This includes instr[1:0] != 2'b11.
- imm is combinational from out_instr and imm_sel.
- FSM states: EMPTY (0 entries), BUSY (main valid), FULL (main and skid valid).
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered from the next state.
- Transitions:
  - EMPTY: accept -> BUSY, main <= input. Otherwise stay.
  - BUSY, accept & consume -> BUSY, main <= input.
  - BUSY, accept & !consume -> FULL, skid <= input.
  - BUSY, !accept & consume -> EMPTY.
  - BUSY, neither -> stay.
  - FULL: consume -> BUSY, main <= skid. Otherwise stay. No accept is possible (in_ready=0).
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 instruction per cycle when out_ready=1.
- flush has highest priority:
  - Next state is EMPTY and both entries are discarded.
  - A beat offered in the same cycle is dropped even if in_ready=1.
  - The cycle after flush: out_valid=0, in_ready=1.
- Simultaneous consume and flush: the consume completes (execute saw the handshake), then the buffer empties.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock edge.
- Entries are never reordered or duplicated; ordering is strictly FIFO.

Optional Feature:
- Macro: DECODE_PERF_EN.
- When defined, two extra output ports are added, each reset to 0 and saturating at 32'hFFFF_FFFF:
  - stall_cnt [31:0]: increments every cycle with out_valid & !out_ready.
  - illegal_cnt [31:0]: increments on each consumed beat with illegal=1.
- flush does not clear either counter.
- When undefined, neither port nor the counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset then in_valid=1, in_instr=32'h0000_0013 (addi), out_ready=1 -> next cycle out_valid=1, imm_sel=1, imm=0, illegal=0.
- Back-to-back stream: sw 32'hFE11_2E23, beq 32'hFE00_0EE3, lui 32'h1234_50B7, jal 32'h0080_00EF at one per cycle with out_ready=1 -> in order:
  - sw: imm_sel=2, imm=32'hFFFF_FFFC.
  - beq: imm_sel=3, imm=32'hFFFF_FFFC.
  - lui: imm_sel=4, imm=32'h1234_5000.
  - jal: imm_sel=5, imm=32'h0000_0008.
  - No bubbles, in_ready held at 1.
- Backpressure: out_ready=0 while 3 beats are offered -> 2 accepted, in_ready=0 from the cycle after the second accept. Then out_ready=1 -> the two drain in order, and in_ready returns to 1 one cycle after the first consume.
- Illegal: in_instr=32'h0000_007F -> illegal=1, imm_sel=0, imm=0. With DECODE_PERF_EN, illegal_cnt=1 after consume.
- Flush in the FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1. The offered beat never appears at the output.
- Async reset pulse between clock edges while BUSY -> out_valid drops immediately; out_instr=32'h0000_0013.
